// File: rtl/memory_arbiter_if.sv
`default_nettype none
// ============================================================
// memory_arbiter_if : fetch, data and backing-memory port bundle
// Rev 1.0
// ============================================================
interface memory_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Fetch side
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_readdata;
   logic              i_busywait;
   // Data side
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_writedata;
   logic [DATA_W-1:0] d_readdata;
   logic              d_busywait;
   // Backing memory
   logic              m_read;
   logic              m_write;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_writedata;
   logic [DATA_W-1:0] m_readdata;
   logic              m_busywait;

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_writedata,
             m_readdata, m_busywait,
      output i_readdata, i_busywait, d_readdata, d_busywait,
             m_read, m_write, m_addr, m_writedata
   );

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_writedata,
             m_readdata, m_busywait,
      input  i_readdata, i_busywait, d_readdata, d_busywait,
             m_read, m_write, m_addr, m_writedata
   );
endinterface
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================
// memory_arbiter : fair fetch/data arbiter onto one backing memory
// Rev 1.0
// ============================================================
module memory_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   memory_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GNT_I = 3'd1,
      GNT_D = 3'd2,
      RSP_I = 3'd3,
      RSP_D = 3'd4
   } state_t;

   localparam logic c_GRANT_I = 1'b0;
   localparam logic c_GRANT_D = 1'b1;

   state_t            r_state;
   state_t            w_next;
   logic              r_last_grant;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_is_write;
   logic [DATA_W-1:0] r_i_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              w_i_req;
   logic              w_d_req;
   logic              w_grant_i;
   logic              w_grant_d;

   assign w_i_req = bus.i_read;
   assign w_d_req = bus.d_read | bus.d_write;

   always_comb begin
      w_next    = r_state;
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
      case (r_state)
         IDLE: begin
            // On a tie the side that did not win last time goes first
            if (w_i_req && (!w_d_req || r_last_grant == c_GRANT_D)) begin
               w_next    = GNT_I;
               w_grant_i = 1'b1;
            end else if (w_d_req) begin
               w_next    = GNT_D;
               w_grant_d = 1'b1;
            end
         end
         GNT_I:   if (!bus.m_busywait) w_next = RSP_I;
         GNT_D:   if (!bus.m_busywait) w_next = RSP_D;
         RSP_I:   w_next = IDLE;
         RSP_D:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= c_GRANT_I;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_is_write   <= 1'b0;
         r_i_rdata    <= '0;
         r_d_rdata    <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant_i) begin
            r_last_grant <= c_GRANT_I;
            r_addr       <= bus.i_addr;
            r_is_write   <= 1'b0;
         end
         if (w_grant_d) begin
            r_last_grant <= c_GRANT_D;
            r_addr       <= bus.d_addr;
            r_wdata      <= bus.d_writedata;
            r_is_write   <= bus.d_write;
         end
         // Capture even if the requester has gone away; it simply ignores it
         if (r_state == GNT_I && !bus.m_busywait)
            r_i_rdata <= bus.m_readdata;
         if (r_state == GNT_D && !bus.m_busywait && !r_is_write)
            r_d_rdata <= bus.m_readdata;
      end
   end

   assign bus.m_read      = (r_state == GNT_I) || (r_state == GNT_D && !r_is_write);
   assign bus.m_write     = (r_state == GNT_D) && r_is_write;
   assign bus.m_addr      = r_addr;
   assign bus.m_writedata = r_wdata;
   assign bus.i_readdata  = r_i_rdata;
   assign bus.d_readdata  = r_d_rdata;
   assign bus.i_busywait  = w_i_req && (r_state != RSP_I);
   assign bus.d_busywait  = w_d_req && (r_state != RSP_D);

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================
// tb_memory_arbiter : scoreboard bench with a wait-state memory model
// Rev 1.0
// ============================================================
module tb_memory_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

   memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- environment memory (wait-state model) ----------------
   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int          mem_cnt  = 0;
   int          cur_wait = 0;
   int          wait_cfg = 0;
   logic [31:0] mem_rdata = '0;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] env_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return init_val(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_val(a);
   endfunction

   function automatic int pick_wait();
      if (wait_cfg < 0) return int'($urandom_range(0, 3));
      return wait_cfg;
   endfunction

   assign bus.m_readdata = mem_rdata;
   assign bus.m_busywait = (bus.m_read || bus.m_write) && (mem_cnt < cur_wait);

   initial forever begin
      @(negedge clk);
      mem_rdata = env_rd(bus.m_addr);
   end

   initial forever begin
      @(posedge clk);
      if (bus.m_read || bus.m_write) begin
         if (!bus.m_busywait) begin
            if (bus.m_write) mem[bus.m_addr] = bus.m_writedata;
            mem_cnt <= 0;
         end else begin
            mem_cnt <= mem_cnt + 1;
         end
      end else begin
         mem_cnt  <= 0;
         cur_wait <= pick_wait();
      end
   end

   // ---------------- scoreboard / monitor ----------------
   logic [31:0] iq[$];
   logic [31:0] dq[$];
   logic [31:0] grant_log[$];
   logic [31:0] d_last = '0;
   logic [31:0] last_waddr = '0;
   int n_ibw = 0, n_dbw = 0, n_mrd = 0, n_mwr = 0, n_mrd_rise = 0;
   logic prev_rd = 1'b0, prev_wr = 1'b0;

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (bus.i_busywait) n_ibw++;
         if (bus.d_busywait) n_dbw++;
         if (bus.m_read)     n_mrd++;
         if (bus.m_write)    n_mwr++;
         if (bus.m_read && !prev_rd) n_mrd_rise++;
         if ((bus.m_read || bus.m_write) && !(prev_rd || prev_wr))
            grant_log.push_back(bus.m_addr);
         if (bus.m_write) last_waddr = bus.m_addr;
         if (bus.m_read || bus.m_write)
            chk("single_cmd", {31'b0, bus.m_read & bus.m_write}, 32'd0);
         if (bus.i_read && !bus.i_busywait) begin
            if (iq.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL i_rsp: got unexpected response expected none");
            end else chk("i_readdata", bus.i_readdata, iq.pop_front());
         end
         if ((bus.d_read || bus.d_write) && !bus.d_busywait) begin
            if (dq.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL d_rsp: got unexpected response expected none");
            end else chk("d_readdata", bus.d_readdata, dq.pop_front());
         end
      end
      prev_rd = bus.m_read;
      prev_wr = bus.m_write;
   end

   // ---------------- drivers (enter and leave at posedge+1) ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_wait(input int n);
      wait_cfg = n;
      tick();
   endtask

   task automatic i_req(input logic [31:0] addr);
      int t = 0;
      bus.i_read = 1'b1;
      bus.i_addr = addr;
      iq.push_back(ref_rd(addr));
      forever begin
         @(negedge clk);
         if (!bus.i_busywait) break;
         t++;
         if (t > 100) begin
            vectors++; miscompares++;
            $display("FAIL i_timeout: got no response expected response within 100 cycles");
            break;
         end
      end
      tick();
      bus.i_read = 1'b0;
   endtask

   task automatic d_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata);
      int t = 0;
      bus.d_read      = rd;
      bus.d_write     = wr;
      bus.d_addr      = addr;
      bus.d_writedata = wdata;
      if (wr) begin
         ref_mem[addr] = wdata;
         dq.push_back(d_last);
      end else begin
         d_last = ref_rd(addr);
         dq.push_back(d_last);
      end
      forever begin
         @(negedge clk);
         if (!bus.d_busywait) break;
         t++;
         if (t > 100) begin
            vectors++; miscompares++;
            $display("FAIL d_timeout: got no response expected response within 100 cycles");
            break;
         end
      end
      tick();
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int gl;
      bus.i_read = 1'b0; bus.i_addr = '0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_writedata = '0;
      wait_cfg = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_i_readdata", bus.i_readdata, 32'd0);
      chk("rst_d_readdata", bus.d_readdata, 32'd0);
      chk("rst_m_read",     {31'b0, bus.m_read},  32'd0);
      chk("rst_m_write",    {31'b0, bus.m_write}, 32'd0);
      chk("rst_m_addr",     bus.m_addr, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // First tie goes to data; data re-requests, second tie goes to fetch
      gl = grant_log.size();
      fork
         i_req(32'h10);
         begin
            d_req(1'b1, 1'b0, 32'h800, 32'h0);
            d_req(1'b1, 1'b0, 32'h804, 32'h0);
         end
      join
      chk("tie_grants", grant_log.size() - gl, 32'd3);
      if (grant_log.size() >= gl + 3) begin
         chk("tie1_winner", grant_log[gl],     32'h800);
         chk("tie2_winner", grant_log[gl + 1], 32'h10);
         chk("tie_third",   grant_log[gl + 2], 32'h804);
      end

      // Zero-wait fetch
      mem[32'h100] = 32'hDEADBEEF;
      ref_mem[32'h100] = 32'hDEADBEEF;
      set_wait(0);
      n_ibw = 0; n_mrd = 0;
      i_req(32'h100);
      chk("fetch_stall",   n_ibw, 32'd2);
      chk("fetch_m_read",  n_mrd, 32'd1);
      chk("fetch_data",    bus.i_readdata, 32'hDEADBEEF);

      // Store with three busy cycles
      set_wait(3);
      n_dbw = 0; n_mwr = 0;
      d_req(1'b0, 1'b1, 32'h40, 32'h12345678);
      chk("store_stall",   n_dbw, 32'd5);
      chk("store_m_write", n_mwr, 32'd4);
      chk("store_m_addr",  last_waddr, 32'h40);
      chk("store_mem",     env_rd(32'h40), 32'h12345678);
      chk("store_keeps_rd", bus.d_readdata, d_last);

      // Read+write together is a write
      set_wait(0);
      n_mrd = 0; n_mwr = 0;
      d_req(1'b1, 1'b1, 32'h80, 32'hCAFEF00D);
      chk("rw_m_read",  n_mrd, 32'd0);
      chk("rw_m_write", n_mwr, 32'd1);
      chk("rw_mem",     env_rd(32'h80), 32'hCAFEF00D);

      // Fetch flushed during its grant; data waits behind it
      set_wait(2);
      n_ibw = 0; n_dbw = 0; n_mrd = 0; n_mrd_rise = 0;
      gl = grant_log.size();
      bus.i_read = 1'b1;
      bus.i_addr = 32'h20;
      tick();
      bus.i_read = 1'b0;
      d_req(1'b1, 1'b0, 32'h404, 32'h0);
      chk("flush_i_stall",  n_ibw, 32'd1);
      chk("flush_d_stall",  n_dbw, 32'd8);
      chk("flush_rd_rises", n_mrd_rise, 32'd2);
      chk("flush_rd_cycles", n_mrd, 32'd6);
      if (grant_log.size() >= gl + 2) begin
         chk("flush_first", grant_log[gl],     32'h20);
         chk("flush_second", grant_log[gl + 1], 32'h404);
      end else chk("flush_grants", grant_log.size() - gl, 32'd2);

      // Asynchronous reset during a stalled store
      set_wait(5);
      bus.d_write = 1'b1;
      bus.d_addr = 32'h408;
      bus.d_writedata = 32'h0BADF00D;
      tick();
      chk("pre_rst_m_write",   {31'b0, bus.m_write},    32'd1);
      chk("pre_rst_busywait",  {31'b0, bus.m_busywait}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_drop_m_write",  {31'b0, bus.m_write},  32'd0);
      chk("rst_drop_m_read",   {31'b0, bus.m_read},   32'd0);
      chk("rst_i_rd_clear",    bus.i_readdata, 32'd0);
      chk("rst_d_rd_clear",    bus.d_readdata, 32'd0);
      chk("rst_d_busywait",    {31'b0, bus.d_busywait}, 32'd1);
      bus.d_write = 1'b0;
      #1;
      chk("rst_d_busy_idle",   {31'b0, bus.d_busywait}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      d_last = '0;
      set_wait(1);
      d_req(1'b1, 1'b0, 32'h408, 32'h0);
      i_req(32'h24);

      // Randomised traffic from both sides
      wait_cfg = -1;
      fork
         for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            i_req({24'h0, 6'($urandom), 2'b00});
         end
         for (int k = 0; k < 40; k++) begin
            int op;
            op = int'($urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) tick();
            d_req(op != 1, op != 0, 32'h400 + {26'h0, 4'($urandom), 2'b00}, $urandom);
         end
      join

      repeat (3) tick();
      chk("iq_drained", iq.size(), 32'd0);
      chk("dq_drained", dq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
